// File: rtl/store_addr_queue_pkg.sv
// ============================================================
// store_addr_queue_pkg : shared store-queue types and helpers
// Revision: 1.0
// ============================================================
`default_nettype none

package store_addr_queue_pkg;

  typedef logic [3:0] B_MASK;
  typedef logic [3:0] BYTE_MASK;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } MEM_SIZE;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    BYTE_MASK    byte_mask;
    B_MASK       bm;
    logic        misaligned;
  } STORE_AQ_ENTRY;

  localparam STORE_AQ_ENTRY NOP_STORE_AQ_ENTRY = '0;

  // Unshifted byte lanes touched by an access of the given size.
  function automatic BYTE_MASK size_base_mask(input MEM_SIZE size);
    case (size)
      BYTE:    size_base_mask = 4'b0001;
      HALF:    size_base_mask = 4'b0011;
      WORD:    size_base_mask = 4'b1111;
      default: size_base_mask = 4'b0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_addr_queue_if.sv
// ============================================================
// store_addr_queue_if : issue and store-queue handshake bundle
// Revision: 1.0
// ============================================================
`default_nettype none

interface store_addr_queue_if
  import store_addr_queue_pkg::*;
#(
  parameter int BM_W = $bits(B_MASK)
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_rs1;
  logic [31:0]     in_rs2;
  logic [31:0]     in_imm;
  logic [2:0]      in_func;
  logic [BM_W-1:0] in_bm;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_addr;
  logic [31:0]     out_data;
  logic [3:0]      out_byte_mask;
  logic [BM_W-1:0] out_bm;
  logic            out_misaligned;

  modport master (
    output in_valid, in_rs1, in_rs2, in_imm, in_func, in_bm, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_byte_mask, out_bm,
           out_misaligned
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_imm, in_func, in_bm, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_byte_mask, out_bm,
           out_misaligned
  );
endinterface

`default_nettype wire

// File: rtl/store_addr_queue_mask_gen.sv
// ============================================================
// store_mask_gen : store address, lane-aligned data, byte mask
// Revision: 1.0
// ============================================================
`default_nettype none

module store_mask_gen
  import store_addr_queue_pkg::*;
(
  input  logic [31:0]   i_rs1,
  input  logic [31:0]   i_rs2,
  input  logic [31:0]   i_imm,
  input  MEM_SIZE       i_size,
  input  B_MASK         i_bm,
  output STORE_AQ_ENTRY o_entry
);

  logic [31:0] w_addr;
  logic [1:0]  w_ofs;
  BYTE_MASK    w_base;

  assign w_addr = i_rs1 + i_imm;
  assign w_ofs  = w_addr[1:0];
  assign w_base = size_base_mask(i_size);

  always_comb begin
    o_entry            = NOP_STORE_AQ_ENTRY;
    o_entry.addr       = w_addr;
    o_entry.data       = i_rs2 << {w_ofs, 3'b000};
    o_entry.byte_mask  = w_base << w_ofs;
    o_entry.bm         = i_bm;
    o_entry.misaligned = ((i_size == HALF) && w_ofs[0]) ||
                         ((i_size == WORD) && (w_ofs != 2'b00));
  end

endmodule

`default_nettype wire

// File: rtl/store_addr_queue.sv
// ============================================================
// store_addr_queue : store address/data FIFO with branch-mask squash
// Revision: 1.0
// ============================================================
`default_nettype none

module store_addr_queue
  import store_addr_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int BM_W  = $bits(B_MASK)
)(
  input  logic                   clock,
  input  logic                   reset,
  store_addr_queue_if.slave      bus,
  input  logic [BM_W-1:0]        b_mm_resolve,
  input  logic                   b_mm_mispred,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  STORE_AQ_ENTRY        r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_CNT_W-1:0]   r_count;

  B_MASK                w_res;
  logic                 w_clear;
  logic [DEPTH-1:0]     w_match;
  logic [c_CNT_W-1:0]   w_keep;
  logic                 w_squash;
  logic                 w_head_hit;
  logic                 w_in_hit;
  logic                 w_enq;
  logic                 w_deq;
  logic [c_PTR_W-1:0]   w_tail_base;
  logic [c_CNT_W-1:0]   w_cnt_base;
  B_MASK                w_keep_bits;
  STORE_AQ_ENTRY        w_new;
  STORE_AQ_ENTRY        w_new_wr;
  STORE_AQ_ENTRY        w_head;

  // Stored branch masks use the package B_MASK width.
  assign w_res       = B_MASK'(b_mm_resolve);
  assign w_clear     = !b_mm_mispred && (w_res != '0);
  assign w_keep_bits = w_clear ? ~w_res : '1;

  store_mask_gen u_mask_gen (
    .i_rs1   (bus.in_rs1),
    .i_rs2   (bus.in_rs2),
    .i_imm   (bus.in_imm),
    .i_size  (MEM_SIZE'(bus.in_func[1:0])),
    .i_bm    (B_MASK'(bus.in_bm)),
    .o_entry (w_new)
  );

  always_comb begin
    w_new_wr    = w_new;
    w_new_wr.bm = w_new.bm & w_keep_bits;
  end

  // Match vector indexed by age offset from the head.
  for (genvar o = 0; o < DEPTH; o++) begin : g_match
    logic [c_PTR_W-1:0] w_idx;
    assign w_idx      = r_head + c_PTR_W'(o);
    assign w_match[o] = (c_CNT_W'(o) < r_count) &&
                        ((r_mem[w_idx].bm & w_res) != '0);
  end

  // Matches form a youngest suffix, so the oldest match sets the new tail.
  always_comb begin
    w_keep = r_count;
    for (int o = DEPTH - 1; o >= 0; o--) begin
      if (w_match[o]) w_keep = c_CNT_W'(o);
    end
  end

  assign w_squash    = b_mm_mispred && (w_match != '0);
  assign w_head_hit  = b_mm_mispred && w_match[0];
  assign w_in_hit    = b_mm_mispred && ((w_new.bm & w_res) != '0);

  assign bus.in_ready  = (r_count < c_CNT_W'(DEPTH));
  assign bus.out_valid = (r_count != '0) && !w_head_hit;

  assign w_enq       = bus.in_valid && bus.in_ready && !w_in_hit;
  assign w_deq       = bus.out_valid && bus.out_ready;
  assign w_tail_base = w_squash ? (r_head + c_PTR_W'(w_keep)) : r_tail;
  assign w_cnt_base  = w_squash ? w_keep : r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= NOP_STORE_AQ_ENTRY;
    end else begin
      if (w_clear) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i].bm <= r_mem[i].bm & ~w_res;
      end
      if (w_enq) r_mem[w_tail_base] <= w_new_wr;
      if (w_deq) r_head <= r_head + c_PTR_W'(1);
      r_tail  <= w_tail_base + (w_enq ? c_PTR_W'(1) : c_PTR_W'(0));
      r_count <= w_cnt_base + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);
    end
  end

  assign w_head = r_mem[r_head];

  assign bus.out_addr       = bus.out_valid ? w_head.addr       : '0;
  assign bus.out_data       = bus.out_valid ? w_head.data       : '0;
  assign bus.out_byte_mask  = bus.out_valid ? w_head.byte_mask  : '0;
  assign bus.out_misaligned = bus.out_valid ? w_head.misaligned : 1'b0;
  assign bus.out_bm         = bus.out_valid ? BM_W'(w_head.bm & w_keep_bits) : '0;

  assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_store_addr_queue.sv
// ============================================================
// tb_store_addr_queue : directed self-checking bench
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_store_addr_queue;
  import store_addr_queue_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] b_res = '0;
  logic       b_mis = 1'b0;
  logic [2:0] count;
  int         n_total = 0;
  int         n_bad   = 0;

  store_addr_queue_if #(.BM_W(4)) bus ();

  store_addr_queue #(.DEPTH(4), .BM_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .b_mm_resolve (b_res),
    .b_mm_mispred (b_mis),
    .count        (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] rs1, input logic [31:0] imm,
                       input logic [31:0] rs2, input logic [2:0] func,
                       input logic [3:0] bm);
    bus.in_valid = 1'b1;
    bus.in_rs1   = rs1;
    bus.in_imm   = imm;
    bus.in_rs2   = rs2;
    bus.in_func  = func;
    bus.in_bm    = bm;
  endtask

  task automatic issue(input logic [31:0] rs1, input logic [31:0] imm,
                       input logic [31:0] rs2, input logic [2:0] func,
                       input logic [3:0] bm);
    drive(rs1, imm, rs2, func, bm);
    step();
    bus.in_valid = 1'b0;
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.in_func   = '0;
    bus.in_bm     = '0;
    bus.out_ready = 1'b0;

    // reset state
    step(); step();
    reset = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);

    // byte store, one-cycle latency
    drive(32'h1000, 32'h6, 32'hAB, 3'b000, 4'h0);
    #1;
    chk("sb_lat0", 32'(bus.out_valid), 0);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("sb_valid", 32'(bus.out_valid), 1);
    chk("sb_addr", bus.out_addr, 32'h1006);
    chk("sb_data", bus.out_data, 32'h00AB0000);
    chk("sb_mask", 32'(bus.out_byte_mask), 32'h4);
    chk("sb_mis", 32'(bus.out_misaligned), 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    #1;
    chk("sb_drain", 32'(count), 0);
    chk("idle_addr0", bus.out_addr, 0);

    // half / word / negative immediate / size 3
    issue(32'h1000, 32'h3, 32'h1234, 3'b001, 4'h0);
    issue(32'h1000, 32'h4, 32'hDEADBEEF, 3'b010, 4'h0);
    issue(32'h2000, 32'hFFFFFFFF, 32'h5A, 3'b000, 4'h0);
    issue(32'h0, 32'h2, 32'h77, 3'b011, 4'h0);
    chk("sh_addr", bus.out_addr, 32'h1003);
    chk("sh_data", bus.out_data, 32'h34000000);
    chk("sh_mask", 32'(bus.out_byte_mask), 32'h8);
    chk("sh_mis", 32'(bus.out_misaligned), 1);
    bus.out_ready = 1'b1;
    step();
    chk("sw_data", bus.out_data, 32'hDEADBEEF);
    chk("sw_mask", 32'(bus.out_byte_mask), 32'hF);
    chk("sw_mis", 32'(bus.out_misaligned), 0);
    step();
    chk("neg_addr", bus.out_addr, 32'h1FFF);
    chk("neg_data", bus.out_data, 32'h5A000000);
    chk("neg_mask", 32'(bus.out_byte_mask), 32'h8);
    step();
    chk("sz3_addr", bus.out_addr, 32'h2);
    chk("sz3_mask", 32'(bus.out_byte_mask), 32'h0);
    chk("sz3_mis", 32'(bus.out_misaligned), 0);
    step();
    bus.out_ready = 1'b0;
    chk("mix_drain", 32'(count), 0);

    // fill to DEPTH, reject fifth, full queue ignores issue even while draining
    for (int i = 0; i < 4; i++) issue(32'(i) * 32'h100, 32'h0, 32'(i + 1), 3'b010, 4'h0);
    chk("full_ready", 32'(bus.in_ready), 0);
    chk("full_count", 32'(count), 4);
    issue(32'h500, 32'h0, 32'h5, 3'b010, 4'h0);
    chk("full_reject", 32'(count), 4);
    chk("fifo0", bus.out_data, 1);
    drive(32'h600, 32'h0, 32'h6, 3'b010, 4'h0);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("full_deq_count", 32'(count), 3);
    chk("fifo1", bus.out_data, 2);
    step();
    chk("fifo2", bus.out_data, 3);
    step();
    chk("fifo3", bus.out_data, 4);
    step();
    bus.out_ready = 1'b0;
    chk("fifo_drain", 32'(count), 0);

    // mispredict squashes youngest suffix and matching enqueue
    issue(32'h0, 32'h0, 32'h11, 3'b010, 4'b0001);
    issue(32'h0, 32'h0, 32'h22, 3'b010, 4'b0011);
    issue(32'h0, 32'h0, 32'h33, 3'b010, 4'b0011);
    drive(32'h0, 32'h0, 32'h44, 3'b010, 4'b0010);
    b_mis = 1'b1;
    b_res = 4'b0010;
    #1;
    chk("sq_head_ok", 32'(bus.out_valid), 1);
    step();
    bus.in_valid = 1'b0;
    b_mis = 1'b0;
    b_res = 4'b0000;
    #1;
    chk("sq_count", 32'(count), 1);
    chk("sq_data", bus.out_data, 32'h11);
    chk("sq_bm", 32'(bus.out_bm), 32'h1);
    issue(32'h0, 32'h0, 32'h55, 3'b010, 4'b0000);
    chk("sq_reenq", 32'(count), 2);
    bus.out_ready = 1'b1;
    step();
    chk("sq_tail", bus.out_data, 32'h55);
    step();
    bus.out_ready = 1'b0;
    chk("sq_drain", 32'(count), 0);

    // head hit by mispredict: hidden and not dequeued
    issue(32'h0, 32'h0, 32'h66, 3'b010, 4'b0100);
    b_mis = 1'b1;
    b_res = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    chk("hh_valid", 32'(bus.out_valid), 0);
    chk("hh_data0", bus.out_data, 0);
    step();
    b_mis = 1'b0;
    b_res = 4'b0000;
    bus.out_ready = 1'b0;
    #1;
    chk("hh_count", 32'(count), 0);

    // correct resolve clears bit, entry still delivered
    issue(32'h0, 32'h0, 32'h77, 3'b010, 4'b0100);
    b_res = 4'b0100;
    #1;
    chk("rs_bm_now", 32'(bus.out_bm), 0);
    chk("rs_valid", 32'(bus.out_valid), 1);
    step();
    b_res = 4'b0000;
    #1;
    chk("rs_bm_kept", 32'(bus.out_bm), 0);
    chk("rs_data", bus.out_data, 32'h77);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("rs_drain", 32'(count), 0);

    // reset overrides concurrent enqueue
    for (int i = 0; i < 3; i++) issue(32'h0, 32'h0, 32'(i), 3'b010, 4'h0);
    chk("pre_rst_count", 32'(count), 3);
    drive(32'h0, 32'h0, 32'h99, 3'b010, 4'h0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst2_count", 32'(count), 0);
    chk("rst2_out_valid", 32'(bus.out_valid), 0);
    chk("rst2_in_ready", 32'(bus.in_ready), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_addr_queue.md
STORE_ADDR_QUEUE -- requirements
Module: store_addr_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, buffer entries (power of two, 2..16).
REQ-002 The module SHALL have parameter BM_W, default $bits(B_MASK), branch-mask width.
REQ-003 The module SHALL have port clock  input  1  sole clock; all state on posedge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-low (0 = reset).
REQ-005 The module SHALL have port in_valid  input  1  store-unit issue valid.
REQ-006 The module SHALL have port in_ready  output  1  buffer accepts issue this cycle.
REQ-007 The module SHALL have ports in_rs1, in_rs2, in_imm  input  32 each  base, store data, immediate.
REQ-008 The module SHALL have port in_func  input  3  store funct3; [1:0] is MEM_SIZE.
REQ-009 The module SHALL have port in_bm  input  BM_W  issuing store's branch mask.
REQ-010 The module SHALL have ports out_valid output 1, out_ready input 1, store-queue handshake.
REQ-011 The module SHALL have ports out_addr output 32, out_data output 32, out_byte_mask output 4, out_bm output BM_W, out_misaligned output 1.
REQ-012 The module SHALL have ports b_mm_resolve input BM_W (one-hot or zero) and b_mm_mispred input 1.
REQ-013 The module SHALL have port count output $clog2(DEPTH)+1, valid entries held.

Function
REQ-014 The module SHALL enqueue on in_valid && in_ready and dequeue the head on out_valid && out_ready, both in the same cycle when asserted.
REQ-015 The module SHALL drive in_ready = (count < DEPTH); a full queue SHALL NOT accept even with a simultaneous dequeue.
REQ-016 The module SHALL compute at enqueue: addr = in_rs1 + in_imm mod 2^32; data = in_rs2 << (8*addr[1:0]), truncated to 32 bits.
REQ-017 The module SHALL compute the base mask as BYTE 4'b0001, HALF 4'b0011, WORD 4'b1111, size 2'b11 4'b0000, and byte_mask = (base << addr[1:0]) truncated to 4 bits.
REQ-018 The module SHALL set misaligned = (HALF && addr[0]) || (WORD && addr[1:0] != 0).
REQ-019 The module SHALL present an entry at the outputs no earlier than the cycle after its enqueue (latency 1 when empty), in FIFO order.
REQ-020 On b_mm_resolve != 0 with b_mm_mispred = 0, the module SHALL clear that bit in every stored entry and the enqueuing entry, and out_bm SHALL show it cleared in the same cycle.
REQ-021 On b_mm_mispred = 1, the module SHALL invalidate every entry with (bm & b_mm_resolve) != 0 and SHALL drop the enqueuing entry if it matches.
REQ-022 Matching entries are always a contiguous youngest suffix; the module SHALL pull the tail pointer back to the oldest match and reduce count in the same edge.
REQ-023 If the head matches a mispredict, the module SHALL force out_valid = 0 that cycle and SHALL NOT dequeue.
REQ-024 The module SHALL wrap head and tail pointers modulo DEPTH, with count distinguishing full from empty.
REQ-025 When out_valid = 0, the module SHALL drive the out_* payload outputs to 0.

Reset
REQ-026 On a clock edge with reset = 0, the module SHALL empty the queue, zero the pointers and count, and drive out_valid = 0, overriding any concurrent enqueue, dequeue or squash.
REQ-027 In the first cycle after reset deasserts, in_ready SHALL be 1.

Structure
REQ-028 The shared package SHALL hold B_MASK, BYTE_MASK, MEM_SIZE, the new STORE_AQ_ENTRY struct (addr, data, byte_mask, bm, misaligned) and NOP_STORE_AQ_ENTRY.
REQ-029 The design SHALL place the combinational address/mask/alignment computation in the sub-module store_mask_gen; the top holds the storage, pointers and squash logic.

Verification
REQ-030 Bench SHALL check: rs1=0x1000, imm=0x6, rs2=0xAB, BYTE -> next cycle addr 0x1006, data 0x00AB0000, mask 4'b0100, misaligned 0.
REQ-031 Bench SHALL check: HALF at addr 0x1003 -> mask 4'b1000, misaligned 1; WORD at 0x1004 -> mask 4'b1111, misaligned 0.
REQ-032 Bench SHALL check: DEPTH=4, out_ready=0, five issues -> in_ready=0 after the fourth, fifth not enqueued, count=4; raise out_ready -> four in order.
REQ-033 Bench SHALL check: entries bm 0001, 0011, 0011; mispred resolve 0010 -> count 1, only first remains; same cycle enqueue bm 0010 dropped.
REQ-034 Bench SHALL check: head bm 0100, resolve 0100 with mispred 0 -> out_bm 0000 same cycle, entry still delivered.
REQ-035 Bench SHALL check: reset=0 with 3 entries and in_valid=1 -> next cycle count 0, out_valid 0, in_ready 1.
